// File: rtl/spi_fpga_master_slave.sv
// spi_fpga_master_slave: independent SPI master and SPI slave engines on one clock
module spi_fpga_master_slave #(
  parameter int BIT_PER_SECOND                    = 12500000,
  parameter int CLOCK_FREQUENCY                   = 50000000,
  parameter int PACK_LENGTH                       = 8,
  parameter bit CPOL                              = 1'b0,
  parameter bit CPHA                              = 1'b0,
  parameter bit MASTER_PACK_BIT_SEQUENCE_TRANSMIT = 1'b0,
  parameter bit MASTER_PACK_BIT_SEQUENCE_RECEIVE  = 1'b0,
  parameter bit SLAVE_PACK_BIT_SEQUENCE_TRANSMIT  = 1'b0,
  parameter bit SLAVE_PACK_BIT_SEQUENCE_RECEIVE   = 1'b0
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET_N,
  input  logic                   IN_LAUNCH,
  input  logic [PACK_LENGTH-1:0] IN_MASTER_DATA,
  input  logic                   IN_MISO,
  output logic                   OUT_MOSI,
  output logic                   OUT_CS,
  output logic                   OUT_SCLK,
  output logic [PACK_LENGTH-1:0] OUT_MASTER_RECEIVE_DATA,
  output logic                   OUT_MASTER_ACTION_DONE,
  input  logic [PACK_LENGTH-1:0] IN_SLAVE_TRANSMIT_DATA,
  input  logic                   IN_SLAVE_MOSI,
  input  logic                   IN_SLAVE_CS,
  input  logic                   IN_SLAVE_SCLK,
  output logic                   OUT_SLAVE_MISO,
  output logic [PACK_LENGTH-1:0] OUT_SLAVE_RECEIVE_DATA,
  output logic                   OUT_SLAVE_DONE
);
  localparam int HALF = CLOCK_FREQUENCY / (2 * BIT_PER_SECOND);
  localparam int HW = $clog2(HALF);
  localparam int BW = $clog2(PACK_LENGTH);
  localparam int EW = BW + 1;
  localparam int SW = $clog2(PACK_LENGTH + 1);
  localparam logic [HW-1:0] HMAX = HW'(HALF - 1);
  localparam logic [EW-1:0] EMAX = EW'(2 * PACK_LENGTH - 1);
  localparam logic [SW-1:0] SFULL = SW'(PACK_LENGTH);
  localparam logic [BW-1:0] LAST = BW'(PACK_LENGTH - 1);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SHIFT = 3'd2, HOLD = 3'd3, DONE = 3'd4;

  function automatic logic [BW-1:0] ix(input logic msb, input logic [BW-1:0] n);
    return msb ? LAST - n : n;
  endfunction

  logic [2:0] st_q, st_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [EW-1:0] ec_q, ec_d;
  logic [PACK_LENGTH-1:0] tx_q, tx_d, rx_q, rx_d, mrx_q, mrx_d;
  logic cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, mdone_q, mdone_d, launch_q;
  logic [BW-1:0] bn, bn1;

  assign bn = ec_q[EW-1:1];
  assign bn1 = bn + BW'(1);

  // master sequencing: each phase lasts HALF clocks, SHIFT toggles SCLK at phase end
  always_comb begin
    st_d = st_q;
    hc_d = hc_q;
    ec_d = ec_q;
    tx_d = tx_q;
    rx_d = rx_q;
    mrx_d = mrx_q;
    cs_d = cs_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    mdone_d = 1'b0;
    if (st_q == IDLE) begin
      if (IN_LAUNCH && !launch_q) begin
        st_d = SETUP;
        hc_d = '0;
        ec_d = '0;
        tx_d = IN_MASTER_DATA;
        cs_d = 1'b0;
        mosi_d = CPHA ? 1'b0 : IN_MASTER_DATA[ix(MASTER_PACK_BIT_SEQUENCE_TRANSMIT, BW'(0))];
      end
    end else if (st_q == DONE) st_d = IDLE;
    else if (hc_q != HMAX) hc_d = hc_q + HW'(1);
    else begin
      hc_d = '0;
      if (st_q == SETUP) st_d = SHIFT;
      else if (st_q == HOLD) begin
        st_d = DONE;
        cs_d = 1'b1;
        mosi_d = 1'b0;
        mrx_d = rx_q;
        mdone_d = 1'b1;
      end else begin
        sclk_d = ~sclk_q;
        ec_d = ec_q + EW'(1);
        if (ec_q == EMAX) st_d = HOLD;
        if (ec_q[0] == CPHA) rx_d[ix(MASTER_PACK_BIT_SEQUENCE_RECEIVE, bn)] = IN_MISO;
        else if (CPHA) mosi_d = tx_q[ix(MASTER_PACK_BIT_SEQUENCE_TRANSMIT, bn)];
        else if (ec_q != EMAX) mosi_d = tx_q[ix(MASTER_PACK_BIT_SEQUENCE_TRANSMIT, bn1)];
      end
    end
  end

  // master state and pin registers
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      st_q <= IDLE;
      hc_q <= '0;
      ec_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      mrx_q <= '0;
      cs_q <= 1'b1;
      sclk_q <= CPOL;
      mosi_q <= 1'b0;
      mdone_q <= 1'b0;
      launch_q <= 1'b0;
    end else begin
      st_q <= st_d;
      hc_q <= hc_d;
      ec_q <= ec_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      mrx_q <= mrx_d;
      cs_q <= cs_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      mdone_q <= mdone_d;
      launch_q <= IN_LAUNCH;
    end
  end

  assign OUT_CS = cs_q;
  assign OUT_SCLK = sclk_q;
  assign OUT_MOSI = mosi_q;
  assign OUT_MASTER_RECEIVE_DATA = mrx_q;
  assign OUT_MASTER_ACTION_DONE = mdone_q;

  logic scs_q, ssclk_q, miso_q, miso_d, sdone_q, sdone_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [PACK_LENGTH-1:0] stx_q, stx_d, srx_q, srx_d, sdat_q, sdat_d;
  logic s_lead, s_trail, s_samp, s_drv;

  assign s_lead = (ssclk_q == CPOL) && (IN_SLAVE_SCLK != CPOL);
  assign s_trail = (ssclk_q != CPOL) && (IN_SLAVE_SCLK == CPOL);
  assign s_samp = CPHA ? s_trail : s_lead;
  assign s_drv = CPHA ? s_lead : s_trail;

  // slave: CS high idles, CS fall preloads, then sample/drive on detected SCLK edges
  always_comb begin
    sc_d = sc_q;
    stx_d = stx_q;
    srx_d = srx_q;
    sdat_d = sdat_q;
    miso_d = miso_q;
    sdone_d = 1'b0;
    if (IN_SLAVE_CS) begin
      miso_d = 1'b0;
      sc_d = '0;
    end else if (scs_q) begin
      stx_d = IN_SLAVE_TRANSMIT_DATA;
      sc_d = '0;
      miso_d = CPHA ? 1'b0 : IN_SLAVE_TRANSMIT_DATA[ix(SLAVE_PACK_BIT_SEQUENCE_TRANSMIT, BW'(0))];
    end else if (sc_q != SFULL) begin
      if (s_samp) begin
        srx_d[ix(SLAVE_PACK_BIT_SEQUENCE_RECEIVE, sc_q[BW-1:0])] = IN_SLAVE_MOSI;
        sc_d = sc_q + SW'(1);
        if (sc_d == SFULL) begin
          sdat_d = srx_d;
          sdone_d = 1'b1;
        end
      end else if (s_drv) miso_d = stx_q[ix(SLAVE_PACK_BIT_SEQUENCE_TRANSMIT, sc_q[BW-1:0])];
    end
  end

  // slave registers, including the previous-level copies of the SCLK and CS pins
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      scs_q <= 1'b1;
      ssclk_q <= CPOL;
      sc_q <= '0;
      stx_q <= '0;
      srx_q <= '0;
      sdat_q <= '0;
      miso_q <= 1'b0;
      sdone_q <= 1'b0;
    end else begin
      scs_q <= IN_SLAVE_CS;
      ssclk_q <= IN_SLAVE_SCLK;
      sc_q <= sc_d;
      stx_q <= stx_d;
      srx_q <= srx_d;
      sdat_q <= sdat_d;
      miso_q <= miso_d;
      sdone_q <= sdone_d;
    end
  end

  assign OUT_SLAVE_MISO = miso_q;
  assign OUT_SLAVE_RECEIVE_DATA = sdat_q;
  assign OUT_SLAVE_DONE = sdone_q;
endmodule

// File: tb/tb_spi_fpga_master_slave.sv
// tb_spi_fpga_master_slave: three looped-back configurations checked against a bit-order model
module tb_spi_fpga_master_slave;
  localparam bit CP[3] = '{1'b0, 1'b0, 1'b1};
  localparam bit CH[3] = '{1'b0, 1'b0, 1'b1};
  localparam bit ORD[3] = '{1'b0, 1'b1, 1'b0};

  logic clk, rst_n;
  logic launch[3];
  logic [7:0] mdat[3], sdat[3], mrx[3], srx[3];
  logic mosi[3], cs[3], sclk[3], miso[3], mdone[3], sdone[3];
  logic ovr, bcs, bsclk, bmosi;
  logic s0_cs, s0_sclk, s0_mosi;
  int checks = 0, errors = 0;
  int mdc[3] = '{0, 0, 0};
  int sdc[3] = '{0, 0, 0};

  assign s0_cs = ovr ? bcs : cs[0];
  assign s0_sclk = ovr ? bsclk : sclk[0];
  assign s0_mosi = ovr ? bmosi : mosi[0];

  spi_fpga_master_slave u0 (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_LAUNCH(launch[0]), .IN_MASTER_DATA(mdat[0]),
    .IN_MISO(miso[0]), .OUT_MOSI(mosi[0]), .OUT_CS(cs[0]), .OUT_SCLK(sclk[0]),
    .OUT_MASTER_RECEIVE_DATA(mrx[0]), .OUT_MASTER_ACTION_DONE(mdone[0]),
    .IN_SLAVE_TRANSMIT_DATA(sdat[0]), .IN_SLAVE_MOSI(s0_mosi), .IN_SLAVE_CS(s0_cs),
    .IN_SLAVE_SCLK(s0_sclk), .OUT_SLAVE_MISO(miso[0]), .OUT_SLAVE_RECEIVE_DATA(srx[0]),
    .OUT_SLAVE_DONE(sdone[0]));

  spi_fpga_master_slave #(
    .MASTER_PACK_BIT_SEQUENCE_TRANSMIT(1'b1), .MASTER_PACK_BIT_SEQUENCE_RECEIVE(1'b1),
    .SLAVE_PACK_BIT_SEQUENCE_TRANSMIT(1'b1), .SLAVE_PACK_BIT_SEQUENCE_RECEIVE(1'b1)
  ) u1 (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_LAUNCH(launch[1]), .IN_MASTER_DATA(mdat[1]),
    .IN_MISO(miso[1]), .OUT_MOSI(mosi[1]), .OUT_CS(cs[1]), .OUT_SCLK(sclk[1]),
    .OUT_MASTER_RECEIVE_DATA(mrx[1]), .OUT_MASTER_ACTION_DONE(mdone[1]),
    .IN_SLAVE_TRANSMIT_DATA(sdat[1]), .IN_SLAVE_MOSI(mosi[1]), .IN_SLAVE_CS(cs[1]),
    .IN_SLAVE_SCLK(sclk[1]), .OUT_SLAVE_MISO(miso[1]), .OUT_SLAVE_RECEIVE_DATA(srx[1]),
    .OUT_SLAVE_DONE(sdone[1]));

  spi_fpga_master_slave #(.CPOL(1'b1), .CPHA(1'b1)) u2 (
    .IN_CLOCK(clk), .IN_RESET_N(rst_n), .IN_LAUNCH(launch[2]), .IN_MASTER_DATA(mdat[2]),
    .IN_MISO(miso[2]), .OUT_MOSI(mosi[2]), .OUT_CS(cs[2]), .OUT_SCLK(sclk[2]),
    .OUT_MASTER_RECEIVE_DATA(mrx[2]), .OUT_MASTER_ACTION_DONE(mdone[2]),
    .IN_SLAVE_TRANSMIT_DATA(sdat[2]), .IN_SLAVE_MOSI(mosi[2]), .IN_SLAVE_CS(cs[2]),
    .IN_SLAVE_SCLK(sclk[2]), .OUT_SLAVE_MISO(miso[2]), .OUT_SLAVE_RECEIVE_DATA(srx[2]),
    .OUT_SLAVE_DONE(sdone[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    for (int d = 0; d < 3; d++) begin
      if (mdone[d] === 1'b1) mdc[d]++;
      if (sdone[d] === 1'b1) sdc[d]++;
    end

  function automatic logic [7:0] model_xfer(input logic [7:0] w, input bit txm, input bit rxm);
    bit q[$];
    logic [7:0] r = '0;
    for (int k = 0; k < 8; k++) q.push_back(txm ? w[7-k] : w[k]);
    for (int k = 0; k < 8; k++) r[rxm ? 7-k : k] = q[k];
    return r;
  endfunction

  function automatic logic [7:0] model_seq(input logic [7:0] w, input bit txm);
    logic [7:0] s = '0;
    for (int k = 0; k < 8; k++) s[k] = txm ? w[7-k] : w[k];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic xfer(input int d, input logic [7:0] md, input logic [7:0] sd, input bit hold);
    int csl = 0, rel = -1, k = 0, m0, s0;
    logic ps;
    logic [7:0] seq = '0;
    m0 = mdc[d];
    s0 = sdc[d];
    mdat[d] = md;
    sdat[d] = sd;
    launch[d] = 1'b1;
    ps = sclk[d];
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (cs[d] === 1'b0) csl++;
      if (cs[d] === 1'b0 && rel < 0) rel = c + 5;
      if (hold ? c == 100 : c == rel) launch[d] = 1'b0;
      if (sclk[d] !== ps) begin
        if ((ps == CP[d]) != CH[d] && k < 8) begin
          seq[3'(k)] = mosi[d];
          k++;
        end
        ps = sclk[d];
      end
    end
    launch[d] = 1'b0;
    chk($sformatf("d%0d master_rx", d), mrx[d], model_xfer(sd, ORD[d], ORD[d]));
    chk($sformatf("d%0d slave_rx", d), srx[d], model_xfer(md, ORD[d], ORD[d]));
    chk($sformatf("d%0d master_done_count", d), mdc[d] - m0, 1);
    chk($sformatf("d%0d slave_done_count", d), sdc[d] - s0, 1);
    chk($sformatf("d%0d cs_low_clocks", d), csl, 36);
    chk($sformatf("d%0d mosi_bits", d), k, 8);
    chk($sformatf("d%0d mosi_sequence", d), seq, model_seq(md, ORD[d]));
    chk($sformatf("d%0d sclk_idle", d), sclk[d], CP[d]);
    chk($sformatf("d%0d cs_idle", d), cs[d], 1);
  endtask

  task automatic bang(input logic [7:0] w, input int nb, input int extra, output logic [7:0] mis);
    mis = '0;
    ovr = 1'b1;
    bcs = 1'b1;
    bsclk = 1'b0;
    bmosi = 1'b0;
    @(negedge clk);
    bcs = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < nb + extra; k++) begin
      bmosi = w[3'(k)];
      repeat (2) @(negedge clk);
      if (k < nb) mis[3'(k)] = miso[0];
      bsclk = 1'b1;
      repeat (3) @(negedge clk);
      bsclk = 1'b0;
      repeat (3) @(negedge clk);
    end
    bcs = 1'b1;
    repeat (3) @(negedge clk);
    ovr = 1'b0;
  endtask

  initial begin
    logic [7:0] md, sd, keep, mis;
    int e, m0, s0;
    logic ps;
    ovr = 1'b0;
    bcs = 1'b1;
    bsclk = 1'b0;
    bmosi = 1'b0;
    for (int d = 0; d < 3; d++) begin
      launch[d] = 1'b0;
      mdat[d] = '0;
      sdat[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d reset cs", d), cs[d], 1);
      chk($sformatf("d%0d reset sclk", d), sclk[d], CP[d]);
      chk($sformatf("d%0d reset mosi", d), mosi[d], 0);
      chk($sformatf("d%0d reset miso", d), miso[d], 0);
      chk($sformatf("d%0d reset mrx", d), mrx[d], 0);
      chk($sformatf("d%0d reset srx", d), srx[d], 0);
    end
    xfer(0, 8'hEA, 8'h53, 1'b0);
    xfer(1, 8'hEA, 8'h53, 1'b0);
    xfer(2, 8'hA5, 8'h3C, 1'b0);
    for (int i = 0; i < 4; i++)
      for (int d = 0; d < 3; d++) begin
        md = 8'($urandom);
        sd = 8'($urandom);
        xfer(d, md, sd, 1'b0);
      end
    xfer(0, 8'h96, 8'h0F, 1'b1);
    mdat[0] = 8'h3C;
    sdat[0] = 8'hC3;
    launch[0] = 1'b1;
    m0 = mdc[0];
    s0 = sdc[0];
    e = 0;
    ps = sclk[0];
    for (int c = 0; c < 100 && e < 4; c++) begin
      @(negedge clk);
      if (sclk[0] !== ps) begin
        e++;
        ps = sclk[0];
      end
    end
    chk("midreset edges_reached", e, 4);
    rst_n = 1'b0;
    launch[0] = 1'b0;
    #1;
    chk("midreset cs", cs[0], 1);
    chk("midreset sclk", sclk[0], CP[0]);
    chk("midreset mosi", mosi[0], 0);
    chk("midreset miso", miso[0], 0);
    chk("midreset mrx", mrx[0], 0);
    chk("midreset srx", srx[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midreset master_done_count", mdc[0] - m0, 0);
    chk("midreset slave_done_count", sdc[0] - s0, 0);
    chk("midreset cs_after", cs[0], 1);
    xfer(0, 8'($urandom), 8'($urandom), 1'b0);
    keep = srx[0];
    sdat[0] = 8'h6D;
    s0 = sdc[0];
    bang(8'hB1, 3, 0, mis);
    chk("abort slave_done_count", sdc[0] - s0, 0);
    chk("abort slave_rx_kept", srx[0], keep);
    chk("abort miso_idle", miso[0], 0);
    md = 8'($urandom);
    sdat[0] = 8'($urandom);
    s0 = sdc[0];
    bang(md, 8, 2, mis);
    chk("bang slave_done_count", sdc[0] - s0, 1);
    chk("bang slave_rx", srx[0], model_xfer(md, 1'b0, ORD[0]));
    chk("bang miso_sequence", mis, model_seq(sdat[0], ORD[0]));
    xfer(0, 8'($urandom), 8'($urandom), 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_fpga_master_slave.md
Name: spi_fpga_master_slave

Overview:
- Single-clock block with two independent halves: an SPI master engine and an SPI slave engine, each with its own pin set.
- The bench or top level wires them together: master MOSI/CS/SCLK to slave inputs, and slave MISO to master MISO.
- Master serialises one PACK_LENGTH word per launch and returns the word received on MISO.
- Slave shifts out a preloaded word and captures the word the master sends.

Parameters:
- BIT_PER_SECOND, 12500000, SCLK bit rate.
- CLOCK_FREQUENCY, 50000000, IN_CLOCK frequency. HALF = CLOCK_FREQUENCY/(2*BIT_PER_SECOND) must be an integer >= 2.
- PACK_LENGTH, 8, bits per transfer (>= 2).
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
- MASTER_PACK_BIT_SEQUENCE_TRANSMIT, 0, 1 = MSB first, 0 = LSB first.
- MASTER_PACK_BIT_SEQUENCE_RECEIVE, 0, 1 = first received bit goes to MSB, 0 = to LSB.
- SLAVE_PACK_BIT_SEQUENCE_TRANSMIT, 0, same encoding as the master transmit parameter.
- SLAVE_PACK_BIT_SEQUENCE_RECEIVE, 0, same encoding as the master receive parameter.

Ports:
- IN_CLOCK  in  1  system clock; all logic is on its rising edge.
- IN_RESET_N  in  1  asynchronous, active-low reset.
- IN_LAUNCH  in  1  master start request; acts on its rising edge.
- IN_MASTER_DATA  in  PACK_LENGTH  word to transmit.
- IN_MISO  in  1  master serial input.
- OUT_MOSI  out  1  master serial output.
- OUT_CS  out  1  chip select, active low.
- OUT_SCLK  out  1  serial clock.
- OUT_MASTER_RECEIVE_DATA  out  PACK_LENGTH  last word received by the master.
- OUT_MASTER_ACTION_DONE  out  1  one-clock pulse at end of a master transfer.
- IN_SLAVE_TRANSMIT_DATA  in  PACK_LENGTH  word the slave sends.
- IN_SLAVE_MOSI  in  1  slave serial input.
- IN_SLAVE_CS  in  1  slave chip select input.
- IN_SLAVE_SCLK  in  1  slave serial clock input.
- OUT_SLAVE_MISO  out  1  slave serial output.
- OUT_SLAVE_RECEIVE_DATA  out  PACK_LENGTH  last complete word received by the slave.
- OUT_SLAVE_DONE  out  1  one-clock pulse on slave word completion.

Behaviour:
- Reset values: OUT_CS=1, OUT_SCLK=CPOL, OUT_MOSI=0, OUT_SLAVE_MISO=0, all data outputs 0, all done pulses 0, both FSMs idle.
- Master FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - A registered rising-edge detect on IN_LAUNCH starts a transfer. Holding IN_LAUNCH high yields exactly one transfer.
  - Launch edges while busy are ignored.
- SETUP:
  - On start, latch IN_MASTER_DATA and drive OUT_CS=0.
  - If CPHA=0, drive the first bit on OUT_MOSI in the same clock.
  - Wait HALF clocks.
- SHIFT:
  - Toggle SCLK every HALF clocks, for PACK_LENGTH full periods (2*PACK_LENGTH edges).
  - CPHA=0: sample IN_MISO on each leading edge (at the clock that drives the leading edge); shift MOSI on each trailing edge except the last.
  - CPHA=1: drive MOSI on each leading edge; sample on each trailing edge.
- HOLD:
  - SCLK is back at CPOL. Wait HALF clocks, then set OUT_CS=1 and OUT_MOSI=0.
  - Update OUT_MASTER_RECEIVE_DATA and pulse OUT_MASTER_ACTION_DONE for 1 clock in the same clock.
- DONE: return to IDLE; a new launch edge is accepted from the next clock.
- Master CS-low time is (2*PACK_LENGTH+2)*HALF clocks, i.e. 36 clocks at the defaults.
- Slave input capture:
  - The slave registers IN_SLAVE_SCLK and IN_SLAVE_CS once (no extra synchroniser), so its inputs must be synchronous to IN_CLOCK.
  - Edges are detected by comparing the live pin level against the registered previous level.
  - A leading edge is SCLK leaving CPOL; a trailing edge is SCLK returning to CPOL.
- Slave transfer sequence:
  - CS falling edge detected: load IN_SLAVE_TRANSMIT_DATA and clear the bit counter. If CPHA=0, register the first bit onto OUT_SLAVE_MISO in that same clock.
  - Sampling edge: shift IN_SLAVE_MOSI into the receive register and increment the counter.
  - Drive edge (trailing for CPHA=0, leading for CPHA=1): register the next bit onto MISO.
  - This timing guarantees MISO is valid at least one clock before the master's sampling edge when HALF >= 2.
  - When the counter reaches PACK_LENGTH: update OUT_SLAVE_RECEIVE_DATA and pulse OUT_SLAVE_DONE for 1 clock.
- Slave CS handling:
  - CS high: OUT_SLAVE_MISO=0 and the counter is held at 0.
  - CS rising before PACK_LENGTH bits: abort, with no data update and no pulse.
  - Extra SCLK edges after completion while CS stays low are ignored.
- Bit order: a transmit bit index runs from 0 upward (LSB first) or from PACK_LENGTH-1 downward (MSB first). Receive placement mirrors this.
- Asynchronous reset mid-transfer returns every output to its reset value immediately.

Test Plan:
- Defaults, all orders 0, master data 0xEA, slave data 0x53, launch high, then low 5 clocks after CS falls -> master receives 0x53, slave receives 0xEA, one DONE pulse each, CS low for 36 clocks, MOSI bit sequence 0,1,0,1,0,1,1,1.
- All four orders set to 1, same data -> same received words; MOSI sequence 1,1,1,0,1,0,1,0.
- CPOL=1, CPHA=1, data 0xA5/0x3C -> master gets 0x3C, slave gets 0xA5; SCLK idles high.
- IN_LAUNCH held high for 100 clocks -> exactly one transfer.
- Reset asserted at the 4th SCLK edge -> CS=1, SCLK=CPOL, no done pulses; a following transfer completes correctly.
- Slave CS raised after 3 bits -> no OUT_SLAVE_DONE and OUT_SLAVE_RECEIVE_DATA unchanged; the next full transfer succeeds.
